// File: rtl/sobel_edge_engine.sv
// sobel_edge_engine: streaming 3x3 Sobel gradient magnitude and edge detector
module sobel_edge_engine #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  recv_data_i,
    input  logic [DATA_WIDTH-1:0] pixel_i,
    input  logic                  mag_mode_i,
    input  logic [DATA_WIDTH+2:0] threshold_i,
    output logic [DATA_WIDTH+2:0] gradient_o,
    output logic                  gradient_valid_o,
    output logic                  edge_o,
    output logic                  frame_done_o
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int MW = DATA_WIDTH + 3;
    localparam int SW = DATA_WIDTH + 4;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    pix_t lb1_q [IMG_WIDTH];
    pix_t lb2_q [IMG_WIDTH];
    pix_t lc_q [3];
    pix_t mc_q [3];
    pix_t rc_q [3];
    logic mode_q, mode1_q;
    logic [MW-1:0] thr_q, thr1_q;
    logic wv_q, wl_q, v1_q, last1_q;
    logic signed [SW-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [MW-1:0] ax, ay, mag_d;
    logic col_last, row_last, win_done;

    // weighted column/row sum a + 2b + c, widened so the difference never overflows
    function automatic logic signed [SW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return $signed({4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c});
    endfunction

    assign col_last = col_q == CW'(IMG_WIDTH - 1);
    assign row_last = row_q == RW'(IMG_HEIGHT - 1);
    assign win_done = recv_data_i && row_q >= RW'(2) && col_q >= CW'(2);

    // gradients from the registered window; magnitude from the registered gradients
    always_comb begin
        gx_d  = wsum(rc_q[0], rc_q[1], rc_q[2]) - wsum(lc_q[0], lc_q[1], lc_q[2]);
        gy_d  = wsum(lc_q[2], mc_q[2], rc_q[2]) - wsum(lc_q[0], mc_q[0], rc_q[0]);
        ax    = MW'(gx_q[SW-1] ? -gx_q : gx_q);
        ay    = MW'(gy_q[SW-1] ? -gy_q : gy_q);
        mag_d = mode1_q ? (ax > ay ? ax : ay) : ax + ay;
    end

    // line buffers and window shift on each accepted pixel; contents survive reset
    always_ff @(posedge clk) begin
        if (recv_data_i) begin
            lb1_q[col_q] <= pixel_i;
            lb2_q[col_q] <= lb1_q[col_q];
            lc_q         <= mc_q;
            mc_q         <= rc_q;
            rc_q         <= '{lb2_q[col_q], lb1_q[col_q], pixel_i};
        end
    end

    // counters, config latch and the two-stage result pipeline; config travels with each window
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q            <= '0;
            row_q            <= '0;
            mode_q           <= 1'b0;
            thr_q            <= '0;
            wv_q             <= 1'b0;
            wl_q             <= 1'b0;
            v1_q             <= 1'b0;
            last1_q          <= 1'b0;
            gx_q             <= '0;
            gy_q             <= '0;
            mode1_q          <= 1'b0;
            thr1_q           <= '0;
            gradient_o       <= '0;
            gradient_valid_o <= 1'b0;
            edge_o           <= 1'b0;
            frame_done_o     <= 1'b0;
        end else begin
            if (recv_data_i) begin
                col_q <= col_last ? '0 : col_q + 1'b1;
                row_q <= col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
                if (col_q == '0 && row_q == '0) begin
                    mode_q <= mag_mode_i;
                    thr_q  <= threshold_i;
                end
            end
            wv_q    <= win_done;
            wl_q    <= win_done && row_last && col_last;
            v1_q    <= wv_q;
            last1_q <= wl_q;
            if (wv_q) begin
                gx_q    <= gx_d;
                gy_q    <= gy_d;
                mode1_q <= mode_q;
                thr1_q  <= thr_q;
            end
            gradient_valid_o <= v1_q;
            frame_done_o     <= v1_q && last1_q;
            if (v1_q) begin
                gradient_o <= mag_d;
                edge_o     <= mag_d >= thr1_q;
            end
        end
    end
endmodule
